// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: the carry ripples through one operand slice per stage behind a valid/ready pipeline.
// Optional macro PIPELINED_ADDER_SATURATE_EN clamps sum on overflow (all-ones) and underflow (zero).
module pipelined_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int unsigned SLICE = (WIDTH + STAGES - 1) / STAGES;

  // Per-stage registers: operands ride along with the partial sum and slice carry.
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] st_c;
  logic              st_op [STAGES];
  logic [WIDTH-1:0]  st_a  [STAGES];
  logic [WIDTH-1:0]  st_b  [STAGES];
  logic [WIDTH-1:0]  st_s  [STAGES];

  logic [STAGES-1:0] nx_v;
  logic [STAGES-1:0] nx_c;
  logic              nx_op [STAGES];
  logic [WIDTH-1:0]  nx_a  [STAGES];
  logic [WIDTH-1:0]  nx_b  [STAGES];
  logic [WIDTH-1:0]  nx_s  [STAGES];

  logic [WIDTH-1:0]  cur_a;
  logic [WIDTH-1:0]  cur_b;
  logic [WIDTH-1:0]  cur_s;
  logic              cur_v;
  logic              cur_c;
  logic              cur_op;
  logic              adv;

  assign adv       = ~vld[STAGES-1] | out_ready;
  assign in_ready  = ~rst & adv;
  assign out_valid = vld[STAGES-1];
  assign sum       = st_s[STAGES-1];
  assign carry     = st_c[STAGES-1];
  assign ovf       = st_c[STAGES-1];

  // Next contents of every stage; bit i is summed in stage i/SLICE.
  always_comb begin
    cur_a  = '0;
    cur_b  = '0;
    cur_s  = '0;
    cur_v  = 1'b0;
    cur_c  = 1'b0;
    cur_op = 1'b0;
    nx_v   = '0;
    nx_c   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        cur_v  = in_valid;
        cur_a  = a;
        cur_b  = op ? ~b : b;
        cur_s  = '0;
        cur_c  = op;
        cur_op = op;
      end else begin
        cur_v  = vld[k-1];
        cur_a  = st_a[k-1];
        cur_b  = st_b[k-1];
        cur_s  = st_s[k-1];
        cur_c  = st_c[k-1];
        cur_op = st_op[k-1];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if ((i / SLICE) == k) begin
          cur_s[i] = cur_a[i] ^ cur_b[i] ^ cur_c;
          cur_c    = (cur_a[i] & cur_b[i]) | (cur_c & (cur_a[i] ^ cur_b[i]));
        end
      end
      if (k == STAGES - 1) begin
        // Subtract carries out when no borrow occurred, so invert to report the borrow.
        cur_c = cur_c ^ cur_op;
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (cur_c) begin
          cur_s = cur_op ? '0 : '1;
        end
`endif
      end
      nx_v[k]  = cur_v;
      nx_c[k]  = cur_c;
      nx_op[k] = cur_op;
      nx_a[k]  = cur_a;
      nx_b[k]  = cur_b;
      nx_s[k]  = cur_s;
    end
  end

  // Whole pipeline advances together; a stage keeps its data when its upstream is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= '0;
      st_c <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_op[k] <= 1'b0;
        st_a[k]  <= '0;
        st_b[k]  <= '0;
        st_s[k]  <= '0;
      end
    end else if (adv) begin
      vld <= nx_v;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (nx_v[k]) begin
          st_c[k]  <= nx_c[k];
          st_op[k] <= nx_op[k];
          st_a[k]  <= nx_a[k];
          st_b[k]  <= nx_b[k];
          st_s[k]  <= nx_s[k];
        end
      end
    end
  end

endmodule
